sym_vn_rank_dbuf: RTL
=====================

Name: sym_vn_rank_dbuf

Overview:
- Parametrised, double-buffered successor of the symmetric VN rank LUT.
- Serves VNU_NUM independent read ports of QUAN_SIZE-bit rank entries from an active bank.
- A handshaked stream reload engine fills the shadow bank in the background; the banks are swapped atomically on request.
- Sits between the IB-LUT configuration loader and the VNU array, so the LUT can be re-programmed per iteration/layer without stalling decoding.

Parameters:
- VNU_NUM, 2: number of independent read ports (VNUs served).
- QUAN_SIZE, 3: entry width in bits.
- ADDR_W, 5: page address width; DEPTH = 2**ADDR_W entries per bank (derived, not overridable).

Ports:
- write_clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- page_addr  in  VNU_NUM*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_en  in  1  read enable, common to all ports.
- lut_data  out  VNU_NUM*QUAN_SIZE  registered read data; port k at bits [k*QUAN_SIZE +: QUAN_SIZE].
- load_start  in  1  pulse; begin (or restart) a shadow-bank reload.
- load_data  in  QUAN_SIZE  reload entry.
- load_valid  in  1  load_data valid.
- load_ready  out  1  engine accepts load_data.
- load_done  out  1  one-cycle pulse; shadow bank completely written.
- swap_req  in  1  pulse; request active/shadow exchange.
- active_bank  out  1  index of the bank currently read (0/1).
- swap_err  out  1  sticky; swap_req arrived while the shadow bank was not full.

Behaviour:
- Storage: two banks of DEPTH x QUAN_SIZE. Bank contents are not reset.
- Reset values (asynchronous): state=IDLE, wr_cnt=0, active_bank=0, lut_data=0, load_ready=0, load_done=0, swap_err=0.
- Reads:
  - At a clock edge with rd_en=1, lut_data[k] <= bank[active_bank][page_addr[k]] for every k. Latency is 1 cycle.
  - When rd_en=0, lut_data holds its value.
  - Ports are fully independent; identical addresses on several ports are legal.
- FSM states IDLE, LOAD, FULL:
  - IDLE: load_start -> LOAD with wr_cnt=0.
  - LOAD: load_ready=1. Each cycle with load_valid=1, bank[~active_bank][wr_cnt] <= load_data and wr_cnt increments. When the accepted write has wr_cnt==DEPTH-1: wr_cnt wraps to 0, go to FULL, and load_done=1 in the following cycle (exactly one cycle).
  - load_valid=0 in LOAD: no write and no count; the engine waits indefinitely.
  - load_start in LOAD: wr_cnt restarts at 0. A beat presented in that same cycle is written at address 0 and wr_cnt becomes 1. Stay in LOAD.
  - FULL: load_ready=0. swap_req -> active_bank toggles at that edge, then IDLE. load_start in FULL -> LOAD with wr_cnt=0; the previous shadow contents are overwritten progressively.
- Swap timing:
  - A read sampled at the same edge as the swap uses the old bank. The first read from the new bank is the one sampled at the next edge.
  - swap_req together with load_start in FULL: the swap wins, then go to IDLE; load_start is ignored.
- swap_err:
  - Set on swap_req in IDLE or LOAD; no swap occurs.
  - Cleared only by load_start or rst.
- Reset mid-load: the FSM returns to IDLE and active_bank returns to 0. The partially written shadow contents are undefined; a full reload is required before any swap.
- Read/write collisions cannot occur: reads target the active bank only and writes target the shadow bank only.
- Every valid beat in LOAD is accepted; there is no back-pressure other than load_ready=0 outside LOAD.

Test Plan:
- Reset, load_start, then 32 beats load_data=i%8 with load_valid=1 continuously -> load_ready high for exactly 32 cycles; load_done pulses 1 cycle after beat 31; state FULL.
- Continue from above with swap_req, then rd_en=1, page_addr port0=5, port1=13 -> active_bank=1; one cycle later lut_data port0=5, port1=5.
- In the swap cycle, rd_en=1 with port0 addr=5 -> the returned data comes from bank0 (old contents). The next read returns 5 from bank1.
- swap_req during LOAD at beat 10 -> swap_err=1, active_bank unchanged, load continues to 32 beats. The next load_start clears swap_err.
- Load with load_valid toggling 1/0 each cycle -> 64 cycles to load_done. load_start issued at beat 20 restarts writes at address 0; a full 32-beat reload follows and read-back matches the second data set.
- rst asserted mid-LOAD (beat 15) -> load_ready drops immediately, active_bank=0, lut_data=0. swap_req afterwards -> swap_err=1 and no swap.

Source files
------------

// File: rtl/sym_vn_rank_dbuf.sv
// Double-buffered symmetric VN rank LUT.
// VNU_NUM read ports see the active bank with one cycle of latency while a
// valid/ready stream reload engine fills the shadow bank; a swap request
// exchanges the two banks atomically once the shadow bank is full.
//
// Reload handshake: a beat transfers on every rising edge where
// load_valid && load_ready. load_ready is high exactly while the engine is
// in LOAD and never depends on load_valid; load_data must be stable while
// load_valid is high. Beats presented while load_ready is low are ignored.
module sym_vn_rank_dbuf #(
    parameter int VNU_NUM   = 2,
    parameter int QUAN_SIZE = 3,
    parameter int ADDR_W    = 5
) (
    input  logic                         write_clk,
    input  logic                         rst,
    input  logic [VNU_NUM*ADDR_W-1:0]    page_addr,
    input  logic                         rd_en,
    output logic [VNU_NUM*QUAN_SIZE-1:0] lut_data,
    input  logic                         load_start,
    input  logic [QUAN_SIZE-1:0]         load_data,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic                         load_done,
    input  logic                         swap_req,
    output logic                         active_bank,
    output logic                         swap_err,
    output logic [1:0]                   dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [ADDR_W-1:0]            wr_cnt_q, wr_cnt_d;
    logic                         active_q, active_d;
    logic                         swap_err_q, swap_err_d;
    logic                         load_done_q, load_done_d;
    logic [VNU_NUM*QUAN_SIZE-1:0] lut_data_q, lut_data_d;

    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;

    logic [QUAN_SIZE-1:0]         bank0_q [DEPTH];
    logic [QUAN_SIZE-1:0]         bank1_q [DEPTH];

    // Reload FSM: write-pointer sequencing, bank swap and sticky swap error.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        active_d    = active_q;
        swap_err_d  = swap_err_q;
        load_done_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    wr_cnt_d   = '0;
                    swap_err_d = 1'b0;
                end
                // Shadow bank is not known to be full: refuse the swap.
                if (swap_req) begin
                    swap_err_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // A restart rewinds the pointer so a beat in the same cycle lands at 0.
                if (load_start) begin
                    wr_addr    = '0;
                    wr_cnt_d   = '0;
                    swap_err_d = 1'b0;
                end
                if (load_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_addr + 1'b1;
                    if (wr_addr == {ADDR_W{1'b1}}) begin
                        state_d     = ST_FULL;
                        load_done_d = 1'b1;
                    end
                end
                if (swap_req) begin
                    swap_err_d = 1'b1;
                end
            end
            ST_FULL: begin
                // Swap has priority over a simultaneous restart request.
                if (swap_req) begin
                    active_d = ~active_q;
                    state_d  = ST_IDLE;
                end else if (load_start) begin
                    state_d    = ST_LOAD;
                    wr_cnt_d   = '0;
                    swap_err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read path: every port looks up the currently active bank.
    always_comb begin
        lut_data_d = lut_data_q;
        if (rd_en) begin
            for (int k = 0; k < VNU_NUM; k++) begin
                if (active_q) begin
                    lut_data_d[k*QUAN_SIZE +: QUAN_SIZE] = bank1_q[page_addr[k*ADDR_W +: ADDR_W]];
                end else begin
                    lut_data_d[k*QUAN_SIZE +: QUAN_SIZE] = bank0_q[page_addr[k*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    // Control and read-data registers with asynchronous reset.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            active_q    <= 1'b0;
            swap_err_q  <= 1'b0;
            load_done_q <= 1'b0;
            lut_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            active_q    <= active_d;
            swap_err_q  <= swap_err_d;
            load_done_q <= load_done_d;
            lut_data_q  <= lut_data_d;
        end
    end

    // Shadow-bank write port; storage is deliberately left unreset.
    always_ff @(posedge write_clk) begin
        if (wr_en) begin
            if (active_q) begin
                bank0_q[wr_addr] <= load_data;
            end else begin
                bank1_q[wr_addr] <= load_data;
            end
        end
    end

    assign lut_data    = lut_data_q;
    assign load_ready  = (state_q == ST_LOAD);
    assign load_done   = load_done_q;
    assign active_bank = active_q;
    assign swap_err    = swap_err_q;
    assign dbg_state   = state_q;

endmodule
